rc4_prga_decrypt: RTL and testbench

Keystream-generation and decryption stage that runs directly downstream of `arcfour` key scheduling. After scheduling has left the permutation in S memory, this block runs the RC4 PRGA. It XORs each keystream byte with the encrypted-message ROM and writes plaintext to decrypted RAM. It also flags any plaintext byte outside lowercase ASCII/space, so the key-search controller can reject a key early.

---
 rtl/rc4_prga_decrypt.sv | 207 ++++++++++++++++++++
 tb/tb_rc4_prga_decrypt.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generator and message decryptor.
// Runs PRGA over S memory, XORs with ROM, writes plaintext RAM.
module rc4_prga_decrypt #(
  parameter int MSG_LEN     = 32,
  parameter bit EARLY_ABORT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_sig,
  output logic [7:0] s_address,
  output logic [7:0] s_data,
  output logic       s_wren,
  input  logic [7:0] s_q,
  output logic [4:0] rom_address,
  input  logic [7:0] rom_q,
  output logic [4:0] d_address,
  output logic [7:0] d_data,
  output logic       d_wren,
  output logic       prga_finished,
  output logic       invalid,
  output logic [3:0] state_tap
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    RD_SI  = 4'd1,
    CAP_SI = 4'd2,
    RD_SJ  = 4'd3,
    CAP_SJ = 4'd4,
    WR_SI  = 4'd5,
    WR_SJ  = 4'd6,
    RD_F   = 4'd7,
    CAP_F  = 4'd8,
    WR_D   = 4'd9,
    NEXT   = 4'd10,
    DONE   = 4'd11
  } state_t;

  localparam logic [4:0] K_LAST = 5'(MSG_LEN - 1);

  state_t     state, state_n;
  logic [7:0] i, i_n;
  logic [7:0] j, j_n;
  logic [4:0] k, k_n;
  logic [7:0] si, si_n;
  logic [7:0] sj, sj_n;
  logic [7:0] f, f_n;
  logic [7:0] rom_b, rom_b_n;
  logic       invalid_n;
  logic [7:0] s_address_n;
  logic [7:0] s_data_n;
  logic       s_wren_n;
  logic [4:0] rom_address_n;
  logic [4:0] d_address_n;
  logic [7:0] d_data_n;
  logic       d_wren_n;
  logic       fin_n;
  logic       byte_ok;

  assign state_tap = state;

  // Lowercase letters and space are the only acceptable plaintext.
  assign byte_ok = ((d_data >= 8'h61) && (d_data <= 8'h7a))
                || (d_data == 8'h20);

  // Next-state, datapath updates and registered output values.
  always_comb begin
    state_n       = state;
    i_n           = i;
    j_n           = j;
    k_n           = k;
    si_n          = si;
    sj_n          = sj;
    f_n           = f;
    rom_b_n       = rom_b;
    invalid_n     = invalid;
    s_address_n   = s_address;
    s_data_n      = s_data;
    s_wren_n      = 1'b0;
    rom_address_n = rom_address;
    d_address_n   = d_address;
    d_data_n      = d_data;
    d_wren_n      = 1'b0;
    fin_n         = 1'b0;

    unique case (state)
      IDLE: begin
        if (start_sig) begin
          i_n       = 8'd1;
          j_n       = 8'd0;
          k_n       = 5'd0;
          invalid_n = 1'b0;
          state_n   = RD_SI;
        end
      end
      RD_SI:  state_n = CAP_SI;
      CAP_SI: begin
        si_n    = s_q;
        j_n     = j + s_q;
        state_n = RD_SJ;
      end
      RD_SJ:  state_n = CAP_SJ;
      CAP_SJ: begin
        sj_n    = s_q;
        state_n = WR_SI;
      end
      WR_SI:  state_n = WR_SJ;
      WR_SJ:  state_n = RD_F;
      RD_F:   state_n = CAP_F;
      CAP_F: begin
        f_n     = s_q;
        rom_b_n = rom_q;
        state_n = WR_D;
      end
      WR_D: begin
        state_n = NEXT;
        if (!byte_ok) begin
          invalid_n = 1'b1;
          if (EARLY_ABORT) state_n = DONE;
        end
      end
      NEXT: begin
        i_n = i + 8'd1;
        if (k == K_LAST) begin
          state_n = DONE;
        end else begin
          k_n     = k + 5'd1;
          state_n = RD_SI;
        end
      end
      DONE: begin
        if (!start_sig) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the
    // state being entered and the register values it will see.
    unique case (state_n)
      RD_SI: s_address_n = i_n;
      RD_SJ: s_address_n = j_n;
      WR_SI: begin
        s_address_n = i_n;
        s_data_n    = sj_n;
        s_wren_n    = 1'b1;
      end
      WR_SJ: begin
        s_address_n = j_n;
        s_data_n    = si_n;
        s_wren_n    = 1'b1;
      end
      RD_F: begin
        s_address_n   = si_n + sj_n;
        rom_address_n = k_n;
      end
      WR_D: begin
        d_address_n = k_n;
        d_data_n    = f_n ^ rom_b_n;
        d_wren_n    = 1'b1;
      end
      DONE:    fin_n = 1'b1;
      default: ;
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      i             <= 8'd0;
      j             <= 8'd0;
      k             <= 5'd0;
      si            <= 8'd0;
      sj            <= 8'd0;
      f             <= 8'd0;
      rom_b         <= 8'd0;
      invalid       <= 1'b0;
      s_address     <= 8'd0;
      s_data        <= 8'd0;
      s_wren        <= 1'b0;
      rom_address   <= 5'd0;
      d_address     <= 5'd0;
      d_data        <= 8'd0;
      d_wren        <= 1'b0;
      prga_finished <= 1'b0;
    end else begin
      state         <= state_n;
      i             <= i_n;
      j             <= j_n;
      k             <= k_n;
      si            <= si_n;
      sj            <= sj_n;
      f             <= f_n;
      rom_b         <= rom_b_n;
      invalid       <= invalid_n;
      s_address     <= s_address_n;
      s_data        <= s_data_n;
      s_wren        <= s_wren_n;
      rom_address   <= rom_address_n;
      d_address     <= d_address_n;
      d_data        <= d_data_n;
      d_wren        <= d_wren_n;
      prga_finished <= fin_n;
    end
  end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Bench for rc4_prga_decrypt: memory models, RC4 reference
// model and a scoreboard of expected plaintext writes.
module tb_rc4_prga_decrypt;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic st0   = 1'b0;
  logic st1   = 1'b0;
  logic sel   = 1'b0;
  logic ld    = 1'b0;

  logic [7:0] sa0, sd0, sa1, sd1, dd0, dd1;
  logic [4:0] ra0, ra1, da0, da1;
  logic       sw0, sw1, dw0, dw1;
  logic       fin0, fin1, inv0, inv1;
  logic [3:0] tap0, tap1;
  logic [7:0] s_q, rom_q;

  logic [7:0] s_address, s_data, d_data;
  logic [4:0] rom_address, d_address;
  logic       s_wren, d_wren, fin, inv;
  logic [3:0] tap;

  logic [7:0] smem   [256];
  logic [7:0] s_init [256];
  logic [7:0] ms     [256];
  logic [7:0] rom    [32];
  logic [7:0] dmem   [32];
  logic [7:0] ks     [32];

  logic [12:0] sbq [$];
  logic [12:0] sb_e;
  int  n_chk = 0;
  int  n_fail = 0;
  int  n_wr = 0;
  bit  chk2 = 1'b0;
  string pt = "abcdefghijklmnopqrstuvwxyz abcde";

  always #5 clk = ~clk;

  rc4_prga_decrypt #(.MSG_LEN(32), .EARLY_ABORT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start_sig(st0),
    .s_address(sa0), .s_data(sd0), .s_wren(sw0), .s_q(s_q),
    .rom_address(ra0), .rom_q(rom_q),
    .d_address(da0), .d_data(dd0), .d_wren(dw0),
    .prga_finished(fin0), .invalid(inv0), .state_tap(tap0)
  );

  rc4_prga_decrypt #(.MSG_LEN(32), .EARLY_ABORT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .start_sig(st1),
    .s_address(sa1), .s_data(sd1), .s_wren(sw1), .s_q(s_q),
    .rom_address(ra1), .rom_q(rom_q),
    .d_address(da1), .d_data(dd1), .d_wren(dw1),
    .prga_finished(fin1), .invalid(inv1), .state_tap(tap1)
  );

  assign s_address   = sel ? sa1 : sa0;
  assign s_data      = sel ? sd1 : sd0;
  assign s_wren      = sel ? sw1 : sw0;
  assign rom_address = sel ? ra1 : ra0;
  assign d_address   = sel ? da1 : da0;
  assign d_data      = sel ? dd1 : dd0;
  assign d_wren      = sel ? dw1 : dw0;
  assign fin         = sel ? fin1 : fin0;
  assign inv         = sel ? inv1 : inv0;
  assign tap         = sel ? tap1 : tap0;

  // Synchronous-read S memory, ROM and decrypted RAM.
  always @(posedge clk) begin
    if (ld) begin
      for (int a = 0; a < 256; a++) smem[a] <= s_init[a];
    end else if (s_wren) begin
      smem[s_address] <= s_data;
    end
    s_q   <= smem[s_address];
    rom_q <= rom[rom_address];
    if (d_wren) dmem[d_address] <= d_data;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every plaintext write must match the next expected one.
  always @(negedge clk) begin
    if (d_wren) begin
      n_wr++;
      if (sbq.size() == 0) begin
        check("sb_extra_write", 32'(d_address), 32'hffff);
      end else begin
        sb_e = sbq.pop_front();
        check("d_write", 32'({d_address, d_data}), 32'(sb_e));
      end
      if (chk2 && d_address == 5'd1)
        check("ij_swap_s2", 32'(smem[2]), 32'd2);
    end
  end

  // Reference RC4 PRGA over a private copy of S.
  task automatic model(input int n, input bit ea, output bit einv);
    logic [7:0] i8, j8, a, b, f, d;
    for (int x = 0; x < 256; x++) ms[x] = s_init[x];
    i8 = 8'd1;
    j8 = 8'd0;
    einv = 1'b0;
    for (int kk = 0; kk < n; kk++) begin
      a = ms[i8];
      j8 = j8 + a;
      b = ms[j8];
      ms[i8] = b;
      ms[j8] = a;
      f = ms[8'(a + b)];
      ks[kk] = f;
      d = f ^ rom[kk];
      sbq.push_back({5'(kk), d});
      i8 = i8 + 8'd1;
      if (!((d >= 8'h61 && d <= 8'h7a) || d == 8'h20)) begin
        einv = 1'b1;
        if (ea) break;
      end
    end
  endtask

  task automatic load_s();
    @(negedge clk) ld = 1'b1;
    @(negedge clk) ld = 1'b0;
  endtask

  task automatic ident_s();
    for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
  endtask

  task automatic zero_rom();
    for (int a = 0; a < 32; a++) rom[a] = 8'h00;
  endtask

  function automatic int s_diff();
    int nd = 0;
    for (int a = 0; a < 256; a++) if (smem[a] !== ms[a]) nd++;
    return nd;
  endfunction

  // Start the selected DUT and time the run from leaving IDLE.
  task automatic run(input string tag, input int exp_cyc,
                     input int exp_first, input logic exp_inv);
    int c, first;
    bit done;
    @(negedge clk);
    if (sel) st1 = 1'b1;
    else     st0 = 1'b1;
    @(posedge clk);
    c = 0;
    first = 0;
    done = 1'b0;
    while (!done && c < 400) begin
      c++;
      @(negedge clk);
      if (d_wren && first == 0) first = c;
      if (fin) done = 1'b1;
      else @(posedge clk);
    end
    check({tag, "_finished"}, 32'(done), 32'd1);
    check({tag, "_fin_cycle"}, 32'(c), 32'(exp_cyc));
    check({tag, "_first_wr"}, 32'(first), 32'(exp_first));
    check({tag, "_invalid"}, 32'(inv), 32'(exp_inv));
  endtask

  task automatic release_start(input string tag);
    @(negedge clk);
    st0 = 1'b0;
    st1 = 1'b0;
    @(negedge clk);
    check({tag, "_idle_tap"}, 32'(tap), 32'd0);
    check({tag, "_idle_fin"}, 32'(fin), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit e;
    int cnt;
    logic [7:0] jj, tmp;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tap", 32'(tap0), 32'd0);
    check("rst_outs", 32'(|{sa0, sd0, sw0, ra0, da0, dd0, dw0,
                             fin0, inv0}), 32'd0);
    reset = 1'b1;

    // Identity S, zero ROM, no early abort.
    sel = 1'b0;
    ident_s();
    zero_rom();
    load_s();
    model(32, 1'b0, e);
    run("t1", 321, 9, 1'b1);
    check("t1_d0", 32'(dmem[0]), 32'h02);
    check("t1_d1", 32'(dmem[1]), 32'h05);
    check("t1_sb_empty", 32'(sbq.size()), 32'd0);
    check("t1_s_final", 32'(s_diff()), 32'd0);
    release_start("t1");

    // Identity S, early abort on second byte.
    sel = 1'b1;
    ident_s();
    zero_rom();
    rom[0] = 8'h63;
    rom[1] = 8'h05;
    load_s();
    model(32, 1'b1, e);
    n_wr = 0;
    run("t2", 20, 9, 1'b1);
    repeat (3) @(negedge clk);
    check("t2_writes", 32'(n_wr), 32'd2);
    check("t2_d0", 32'(dmem[0]), 32'h61);
    check("t2_d1", 32'(dmem[1]), 32'h00);
    check("t2_sb_empty", 32'(sbq.size()), 32'd0);
    release_start("t2");

    // Known-good key 0x000000: key schedule done here.
    for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
    jj = 8'd0;
    for (int a = 0; a < 256; a++) begin
      jj = jj + s_init[a];
      tmp = s_init[a];
      s_init[a] = s_init[jj];
      s_init[jj] = tmp;
    end
    zero_rom();
    model(32, 1'b0, e);
    sbq.delete();
    for (int a = 0; a < 32; a++) rom[a] = ks[a] ^ 8'(pt[a]);
    load_s();
    model(32, 1'b1, e);
    run("t3", 321, 9, 1'b0);
    cnt = 0;
    for (int a = 0; a < 32; a++) if (dmem[a] !== 8'(pt[a])) cnt++;
    check("t3_plain_mismatches", 32'(cnt), 32'd0);
    check("t3_sb_empty", 32'(sbq.size()), 32'd0);

    // Handshake: DONE held while start stays high.
    repeat (5) @(negedge clk);
    check("hs_done_tap", 32'(tap), 32'd11);
    check("hs_done_fin", 32'(fin), 32'd1);
    release_start("hs");
    repeat (5) @(negedge clk);
    check("hs_no_restart", 32'(tap), 32'd0);

    // Reset in cycle 150 of a run.
    sel = 1'b0;
    ident_s();
    zero_rom();
    load_s();
    model(32, 1'b0, e);
    @(negedge clk) st0 = 1'b1;
    @(posedge clk);
    repeat (150) @(negedge clk);
    reset = 1'b0;
    st0 = 1'b0;
    @(negedge clk);
    sbq.delete();
    check("rm_tap", 32'(tap0), 32'd0);
    check("rm_outs", 32'(|{sa0, sd0, sw0, ra0, da0, dd0, dw0,
                           fin0, inv0}), 32'd0);
    reset = 1'b1;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (sw0 || dw0) cnt++;
    end
    check("rm_no_writes", 32'(cnt), 32'd0);

    // i == j on the second byte.
    ident_s();
    s_init[0] = 8'd1;
    s_init[1] = 8'd0;
    zero_rom();
    load_s();
    model(32, 1'b0, e);
    chk2 = 1'b1;
    run("t6", 321, 9, e);
    chk2 = 1'b0;
    check("t6_s_final", 32'(s_diff()), 32'd0);
    check("t6_sb_empty", 32'(sbq.size()), 32'd0);
    release_start("t6");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
